memory_turn_ctrl: RTL and testbench
===================================

MEMORY_TURN_CTRL -- requirements
Module: memory_turn_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 50_000_000; cycles both picked cards stay shown before resolve (1 s at 50 MHz).
REQ-002 Parameter TURN_CYCLES, default 750_000_000; cycles a player may idle before losing the turn (15 s).
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a game from IDLE or GAME_OVER.
REQ-006 pick_valid  input  1  player card-pick strobe, one cycle.
REQ-007 pick_idx  input  4  picked card index 0..15.
REQ-008 board_sym  input  48  symbol of card i at bits [3i+2:3i]; held stable during a game.
REQ-009 selected1  output  4  first card of current turn.
REQ-010 selected2  output  4  second card of current turn.
REQ-011 par  output  1  registered; 1 while selected1/selected2 symbols match, valid in SHOW.
REQ-012 flip_back  output  1  one-cycle pulse when shown, unmatched cards return to hidden.
REQ-013 card_state  output  32  2 bits per card: HIDDEN=0, SHOWN=1, MATCHED=2.
REQ-014 player  output  1  player whose turn it is.
REQ-015 score0, score1  output  4 each  pairs won per player, 0..8.
REQ-016 game_over  output  1  high in GAME_OVER.
REQ-017 winner  output  2  valid when game_over: 0 player0, 1 player1, 2 tie.

Function
REQ-018 FSM states: IDLE, WAIT_FIRST, WAIT_SECOND, SHOW, RESOLVE, GAME_OVER.
REQ-019 IDLE/GAME_OVER + start -> WAIT_FIRST; all cards HIDDEN, scores 0, player 0, turn timer loaded.
REQ-020 Pick accepted only if pick_valid and card_state[pick_idx]==HIDDEN; others ignored, no state change.
REQ-021 WAIT_FIRST + accepted pick: selected1<=pick_idx, card SHOWN, -> WAIT_SECOND, turn timer reloaded.
REQ-022 WAIT_SECOND + accepted pick: selected2<=pick_idx, card SHOWN, par registered from board_sym compare, show timer loaded, -> SHOW.
REQ-023 SHOW ignores all picks; after exactly SHOW_CYCLES cycles -> RESOLVE.
REQ-024 RESOLVE, one cycle, par=1: both cards MATCHED, current player score +1, player unchanged.
REQ-025 RESOLVE, par=0: both cards HIDDEN, flip_back=1 that cycle, player toggles.
REQ-026 After RESOLVE: if matched pairs==8 -> GAME_OVER, else -> WAIT_FIRST with turn timer reloaded.
REQ-027 Turn timeout in WAIT_FIRST: player toggles, flip_back=0, stay WAIT_FIRST, timer reloaded.
REQ-028 Turn timeout in WAIT_SECOND: selected1 card HIDDEN, flip_back=1, player toggles, -> WAIT_FIRST.
REQ-029 Pick and timeout in same cycle: timeout wins, pick discarded.
REQ-030 start outside IDLE/GAME_OVER ignored.
REQ-031 Winner: higher score wins; equal scores -> 2.
REQ-032 Timers count down, saturating at 0; expiry asserted the cycle count reaches 0; width $clog2(max(SHOW_CYCLES,TURN_CYCLES)+1).

Reset
REQ-033 rst_n low asynchronously forces IDLE, all cards HIDDEN, selected1/2=0, par=0, flip_back=0, player=0, scores 0, game_over=0, winner=0, timers 0.
REQ-034 Reset mid-turn discards shown cards and scores; no flip_back pulse generated.
REQ-035 Release synchronous to clk; first action only after start.

Structure
REQ-036 Package memory_pkg holds card_state_e (HIDDEN/SHOWN/MATCHED), turn_state_e, NUM_CARDS=16, NUM_PAIRS=8.
REQ-037 One sub-module, turn_timer: loadable down-counter with load value, load strobe, expired flag; instantiated twice (show, turn).
REQ-038 Match counter derived from score0+score1; no separate counter.

Verification (SHOW_CYCLES=4, TURN_CYCLES=10)
REQ-039 Pairs symbols (3,6) equal: start, pick 3, pick 6 -> SHOW 4 cycles, par=1, cards MATCHED, score0=1, player stays 0.
REQ-040 Mismatch: pick 3, pick 5 -> par=0, flip_back pulse exactly 1 cycle in RESOLVE, cards HIDDEN, player=1.
REQ-041 Illegal picks: pick 3 twice, pick MATCHED card, pick during SHOW -> all ignored, state unchanged.
REQ-042 Timeout: pick 2, idle 10 cycles -> card 2 HIDDEN, flip_back=1, player toggles; pick+expiry same cycle -> pick dropped.
REQ-043 Full game: 8 matching pairs, player0 wins 5, player1 3 -> game_over=1, winner=0; start restarts with scores 0.
REQ-044 rst_n low during SHOW -> all outputs at reset values immediately, no flip_back.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and sizing for the two-player memory (pairs) game controller.
package memory_pkg;

  localparam int NUM_CARDS = 16;
  localparam int NUM_PAIRS = 8;
  localparam int IDX_W     = 4;
  localparam int SYM_W     = 3;
  localparam int SCORE_W   = 4;

  typedef enum logic [1:0] {
    HIDDEN  = 2'd0,
    SHOWN   = 2'd1,
    MATCHED = 2'd2
  } card_state_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    WAIT_SECOND,
    SHOW,
    RESOLVE,
    GAME_OVER
  } turn_state_e;

  typedef enum logic [1:0] {
    WIN_P0  = 2'd0,
    WIN_P1  = 2'd1,
    WIN_TIE = 2'd2
  } winner_e;

  // Counter width able to hold the larger of the two timer load values.
  function automatic int timer_width(input longint unsigned a, input longint unsigned b);
    longint unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  function automatic logic [SYM_W-1:0] card_sym(input logic [NUM_CARDS*SYM_W-1:0] board,
                                                 input logic [IDX_W-1:0]           idx);
    return board[SYM_W*int'(idx) +: SYM_W];
  endfunction

endpackage

// File: rtl/memory_turn_ctrl_if.sv
// Player/board inputs and game-status outputs of the memory turn controller.
interface memory_turn_ctrl_if;
  import memory_pkg::*;

  logic                           start;
  logic                           pick_valid;
  logic [IDX_W-1:0]               pick_idx;
  logic [NUM_CARDS*SYM_W-1:0]     board_sym;
  logic [IDX_W-1:0]               selected1;
  logic [IDX_W-1:0]               selected2;
  logic                           par;
  logic                           flip_back;
  logic [2*NUM_CARDS-1:0]         card_state;
  logic                           player;
  logic [SCORE_W-1:0]             score0;
  logic [SCORE_W-1:0]             score1;
  logic                           game_over;
  logic [1:0]                     winner;

  modport master (
    output start, pick_valid, pick_idx, board_sym,
    input  selected1, selected2, par, flip_back, card_state,
           player, score0, score1, game_over, winner
  );

  modport slave (
    input  start, pick_valid, pick_idx, board_sym,
    output selected1, selected2, par, flip_back, card_state,
           player, score0, score1, game_over, winner
  );

endinterface

// File: rtl/memory_turn_ctrl_timer.sv
// Loadable saturating down-counter; expired_o flags the cycle whose edge
// takes the count from one to zero.
module turn_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for a 16-card, two-player memory game: picks, show delay,
// match resolution, turn timeout and scoring.
module memory_turn_ctrl
  import memory_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned TURN_CYCLES = 750_000_000
) (
  input logic               clk,
  input logic               rst_n,
  memory_turn_ctrl_if.slave bus
);

  localparam int               CNT_W     = timer_width(SHOW_CYCLES, TURN_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);

  turn_state_e          state_q, state_d;
  logic [IDX_W-1:0]     sel1_q, sel1_d, sel2_q, sel2_d;
  logic                 par_q, par_d;
  logic                 player_q, player_d;
  logic [SCORE_W-1:0]   score0_q, score0_d, score1_q, score1_d;
  card_state_e          card_q [NUM_CARDS];
  card_state_e          card_d [NUM_CARDS];

  logic                 show_load, turn_load, show_expired, turn_expired;
  logic                 flip_back, pick_ok;
  logic [SCORE_W:0]     pairs_won;
  winner_e              winner;
  logic [2*NUM_CARDS-1:0] card_flat;

  turn_timer #(.WIDTH(CNT_W)) u_show_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (show_load),
    .load_val_i (SHOW_LOAD),
    .expired_o  (show_expired)
  );

  turn_timer #(.WIDTH(CNT_W)) u_turn_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (turn_load),
    .load_val_i (TURN_LOAD),
    .expired_o  (turn_expired)
  );

  assign pick_ok   = bus.pick_valid && (card_q[bus.pick_idx] == HIDDEN);
  assign pairs_won = {1'b0, score0_q} + {1'b0, score1_q};

  always_comb begin
    state_d   = state_q;
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    par_d     = par_q;
    player_d  = player_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    card_d    = card_q;
    show_load = 1'b0;
    turn_load = 1'b0;
    flip_back = 1'b0;

    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_CARDS; i++) card_d[i] = HIDDEN;
          score0_d  = '0;
          score1_d  = '0;
          player_d  = 1'b0;
          turn_load = 1'b1;
          state_d   = WAIT_FIRST;
        end
      end

      WAIT_FIRST: begin
        // A timeout in the same cycle as a pick wins; the pick is dropped.
        if (turn_expired) begin
          player_d  = ~player_q;
          turn_load = 1'b1;
        end else if (pick_ok) begin
          sel1_d               = bus.pick_idx;
          card_d[bus.pick_idx] = SHOWN;
          turn_load            = 1'b1;
          state_d              = WAIT_SECOND;
        end
      end

      WAIT_SECOND: begin
        if (turn_expired) begin
          card_d[sel1_q] = HIDDEN;
          flip_back      = 1'b1;
          player_d       = ~player_q;
          turn_load      = 1'b1;
          state_d        = WAIT_FIRST;
        end else if (pick_ok) begin
          sel2_d               = bus.pick_idx;
          card_d[bus.pick_idx] = SHOWN;
          par_d     = (card_sym(bus.board_sym, bus.pick_idx) == card_sym(bus.board_sym, sel1_q));
          show_load = 1'b1;
          state_d   = SHOW;
        end
      end

      SHOW: begin
        if (show_expired) state_d = RESOLVE;
      end

      RESOLVE: begin
        turn_load = 1'b1;
        state_d   = WAIT_FIRST;
        if (par_q) begin
          card_d[sel1_q] = MATCHED;
          card_d[sel2_q] = MATCHED;
          if (player_q) score1_d = score1_q + SCORE_W'(1);
          else          score0_d = score0_q + SCORE_W'(1);
          // This match is the last pair on the board.
          if (pairs_won == (SCORE_W+1)'(NUM_PAIRS - 1)) begin
            turn_load = 1'b0;
            state_d   = GAME_OVER;
          end
        end else begin
          card_d[sel1_q] = HIDDEN;
          card_d[sel2_q] = HIDDEN;
          flip_back      = 1'b1;
          player_d       = ~player_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel1_q   <= '0;
      sel2_q   <= '0;
      par_q    <= 1'b0;
      player_q <= 1'b0;
      score0_q <= '0;
      score1_q <= '0;
      // NOTE: the card array is only 16 entries and must read HIDDEN straight out of reset, so it is reset like ordinary flops.
      for (int i = 0; i < NUM_CARDS; i++) card_q[i] <= HIDDEN;
    end else begin
      state_q  <= state_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      par_q    <= par_d;
      player_q <= player_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      card_q   <= card_d;
    end
  end

  always_comb begin
    winner = WIN_P0;
    if (state_q == GAME_OVER) begin
      if (score1_q > score0_q)       winner = WIN_P1;
      else if (score1_q == score0_q) winner = WIN_TIE;
    end
  end

  always_comb begin
    card_flat = '0;
    for (int i = 0; i < NUM_CARDS; i++) card_flat[2*i +: 2] = card_q[i];
  end

  assign bus.selected1  = sel1_q;
  assign bus.selected2  = sel2_q;
  assign bus.par        = par_q;
  assign bus.flip_back  = flip_back;
  assign bus.card_state = card_flat;
  assign bus.player     = player_q;
  assign bus.score0     = score0_q;
  assign bus.score1     = score1_q;
  assign bus.game_over  = (state_q == GAME_OVER);
  assign bus.winner     = winner;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Directed bench for memory_turn_ctrl with SHOW_CYCLES=4, TURN_CYCLES=10;
// turn outcomes are predicted by a small game model and queued for comparison.
module tb_memory_turn_ctrl;
  import memory_pkg::*;

  localparam int SHOW_CYC = 4;
  localparam int TURN_CYC = 10;

  typedef struct {
    logic [31:0] cards;
    logic        player;
    logic [3:0]  s0;
    logic [3:0]  s1;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  exp_t        exp_q [$];
  logic [1:0]  m_card [16];
  logic        m_player;
  logic [3:0]  m_s0, m_s1;
  logic [3:0]  m_sel1, m_sel2;

  logic [31:0] flip_vec;
  logic [31:0] cs_log [32];
  logic        par_log [32];
  logic        player_log [32];

  memory_turn_ctrl_if bus ();

  memory_turn_ctrl #(
    .SHOW_CYCLES (SHOW_CYC),
    .TURN_CYCLES (TURN_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_pack();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[2*i +: 2] = m_card[i];
    return v;
  endfunction

  function automatic logic [2:0] sym_of(input int i);
    logic [47:0] b;
    b = bus.board_sym;
    return b[3*i +: 3];
  endfunction

  task automatic model_new_game();
    for (int i = 0; i < 16; i++) m_card[i] = HIDDEN;
    m_player = 1'b0;
    m_s0 = '0;
    m_s1 = '0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic do_pick(input int idx);
    @(posedge clk); #1;
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 4'(idx);
    @(posedge clk); #1;
    bus.pick_valid = 1'b0;
  endtask

  // Samples n_max falling edges after the last pick edge; optionally drives a
  // pick at falling edge pick_n so the next rising edge samples it.
  task automatic run_cycles(input int n_max, input int pick_n, input int pick_i);
    flip_vec = '0;
    for (int n = 1; n <= n_max; n++) begin
      @(negedge clk);
      flip_vec[n-1]   = bus.flip_back;
      cs_log[n-1]     = bus.card_state;
      par_log[n-1]    = bus.par;
      player_log[n-1] = bus.player;
      bus.pick_valid  = (n == pick_n);
      if (n == pick_n) bus.pick_idx = 4'(pick_i);
    end
    bus.pick_valid = 1'b0;
  endtask

  task automatic play_turn(input int a, input int b, input int show_pick, input bit dup);
    exp_t        e;
    logic [31:0] snap;
    logic        match;

    m_card[a] = SHOWN;
    m_sel1    = 4'(a);
    do_pick(a);
    @(negedge clk);
    check($sformatf("first_pick_sel1_%0d", a), 32'(bus.selected1), 32'(m_sel1));
    check($sformatf("first_pick_cards_%0d", a), bus.card_state, m_pack());

    if (dup) begin
      do_pick(a);
      @(negedge clk);
      check("dup_pick_cards", bus.card_state, m_pack());
      check("dup_pick_sel2", 32'(bus.selected2), 32'(m_sel2));
    end

    m_card[b] = SHOWN;
    m_sel2    = 4'(b);
    snap      = m_pack();
    match     = (sym_of(a) == sym_of(b));
    if (match) begin
      m_card[a] = MATCHED;
      m_card[b] = MATCHED;
      if (m_player) m_s1 = m_s1 + 4'd1;
      else          m_s0 = m_s0 + 4'd1;
    end else begin
      m_card[a] = HIDDEN;
      m_card[b] = HIDDEN;
      m_player  = ~m_player;
    end
    e.cards  = m_pack();
    e.player = m_player;
    e.s0     = m_s0;
    e.s1     = m_s1;
    exp_q.push_back(e);

    do_pick(b);
    run_cycles(6, (show_pick >= 0) ? 2 : 0, show_pick);

    check($sformatf("turn_%0d_%0d_sel2", a, b), 32'(bus.selected2), 32'(m_sel2));
    check($sformatf("turn_%0d_%0d_par", a, b), 32'(par_log[0]), 32'(match));
    for (int n = 1; n <= 5; n++)
      check($sformatf("turn_%0d_%0d_shown_n%0d", a, b, n), cs_log[n-1], snap);
    check($sformatf("turn_%0d_%0d_flip", a, b), flip_vec, match ? 32'd0 : (32'd1 << 4));

    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check($sformatf("turn_%0d_%0d_cards", a, b), cs_log[5], e.cards);
      check($sformatf("turn_%0d_%0d_player", a, b), 32'(bus.player), 32'(e.player));
      check($sformatf("turn_%0d_%0d_score0", a, b), 32'(bus.score0), 32'(e.s0));
      check($sformatf("turn_%0d_%0d_score1", a, b), 32'(bus.score1), 32'(e.s1));
    end
  endtask

  initial begin : stimulus
    logic [47:0] board;
    int          pair_a [8] = '{0, 2, 3, 5, 8, 10, 12, 14};
    int          pair_b [8] = '{1, 4, 6, 7, 9, 11, 13, 15};
    logic        flip_seen;

    board = '0;
    for (int k = 0; k < 8; k++) begin
      board[3*pair_a[k] +: 3] = 3'(k);
      board[3*pair_b[k] +: 3] = 3'(k);
    end
    bus.board_sym  = board;
    bus.start      = 1'b0;
    bus.pick_valid = 1'b0;
    bus.pick_idx   = '0;
    m_sel1 = '0;
    m_sel2 = '0;
    model_new_game();

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_cards", bus.card_state, 32'd0);
    check("rst_sel1", 32'(bus.selected1), 32'd0);
    check("rst_sel2", 32'(bus.selected2), 32'd0);
    check("rst_par", 32'(bus.par), 32'd0);
    check("rst_flip", 32'(bus.flip_back), 32'd0);
    check("rst_player", 32'(bus.player), 32'd0);
    check("rst_scores", {24'd0, bus.score1, bus.score0}, 32'd0);
    check("rst_game_over", 32'(bus.game_over), 32'd0);
    check("rst_winner", 32'(bus.winner), 32'd0);
    rst_n = 1'b1;

    // No action before start.
    do_pick(3);
    @(negedge clk);
    check("idle_pick_ignored", bus.card_state, 32'd0);

    pulse_start();
    @(negedge clk);
    check("start_cards", bus.card_state, 32'd0);
    check("start_game_over", 32'(bus.game_over), 32'd0);

    // Matching pair (symbols of 3 and 6 equal).
    play_turn(3, 6, -1, 1'b0);

    // Picking an already matched card is ignored.
    do_pick(6);
    @(negedge clk);
    check("matched_pick_cards", bus.card_state, m_pack());
    check("matched_pick_sel1", 32'(bus.selected1), 32'(m_sel1));

    // Mismatch, with a repeated first pick and a pick during SHOW.
    play_turn(0, 5, 1, 1'b1);

    // Second-pick timeout, then a first-pick timeout coinciding with a pick.
    m_card[2] = SHOWN;
    do_pick(2);
    run_cycles(21, 20, 4);
    check("timeout2_shown_n10", cs_log[9], m_pack());
    check("timeout_flip_vec", flip_vec, 32'd1 << 9);
    m_card[2] = HIDDEN;
    check("timeout2_player_n10", 32'(player_log[9]), 32'(m_player));
    m_player = ~m_player;
    check("timeout2_cards", cs_log[10], m_pack());
    check("timeout2_player", 32'(player_log[10]), 32'(m_player));
    check("timeout1_player_before", 32'(player_log[19]), 32'(m_player));
    m_player = ~m_player;
    check("timeout1_pick_dropped", cs_log[20], m_pack());
    check("timeout1_player", 32'(player_log[20]), 32'(m_player));

    // start mid-game is ignored.
    pulse_start();
    @(negedge clk);
    check("midgame_start_cards", bus.card_state, m_pack());
    check("midgame_start_score0", 32'(bus.score0), 32'(m_s0));
    check("midgame_start_player", 32'(bus.player), 32'(m_player));

    // Finish the game: player1 takes 3 pairs, misses, player0 takes 4.
    play_turn(0, 1, -1, 1'b0);
    play_turn(2, 4, -1, 1'b0);
    play_turn(5, 7, -1, 1'b0);
    play_turn(8, 10, -1, 1'b0);
    play_turn(8, 9, -1, 1'b0);
    play_turn(10, 11, -1, 1'b0);
    play_turn(12, 13, -1, 1'b0);
    play_turn(14, 15, -1, 1'b0);
    check("final_game_over", 32'(bus.game_over), 32'd1);
    check("final_winner", 32'(bus.winner), 32'(WIN_P0));
    check("final_score0", 32'(bus.score0), 32'd5);
    check("final_score1", 32'(bus.score1), 32'd3);

    // Restart from GAME_OVER.
    pulse_start();
    @(negedge clk);
    model_new_game();
    check("restart_cards", bus.card_state, 32'd0);
    check("restart_scores", {24'd0, bus.score1, bus.score0}, 32'd0);
    check("restart_game_over", 32'(bus.game_over), 32'd0);
    check("restart_player", 32'(bus.player), 32'd0);

    // Asynchronous reset in the middle of SHOW.
    play_turn(0, 1, -1, 1'b0);
    do_pick(3);
    do_pick(6);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midshow_rst_cards", bus.card_state, 32'd0);
    check("midshow_rst_sel1", 32'(bus.selected1), 32'd0);
    check("midshow_rst_sel2", 32'(bus.selected2), 32'd0);
    check("midshow_rst_par", 32'(bus.par), 32'd0);
    check("midshow_rst_scores", {24'd0, bus.score1, bus.score0}, 32'd0);
    check("midshow_rst_player", 32'(bus.player), 32'd0);
    flip_seen = bus.flip_back;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      flip_seen = flip_seen | bus.flip_back;
    end
    check("midshow_rst_no_flip", 32'(flip_seen), 32'd0);
    rst_n = 1'b1;

    do_pick(5);
    @(negedge clk);
    check("post_rst_pick_ignored", bus.card_state, 32'd0);
    pulse_start();
    do_pick(5);
    @(negedge clk);
    check("post_rst_start_pick", bus.card_state, 32'd1 << 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
